// File: rtl/fwrisc_alu_seq.sv
// Handshaked execute-stage ALU. Single-cycle compare/logic ops plus iterative
// shifts, shift-add multiply-low and restoring unsigned divide/remainder.
module fwrisc_alu_seq #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [4:0]       op,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] STEP_C  = CW'(SHIFT_STEP);
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_AND = 5'd2,  OP_OR  = 5'd3;
  localparam logic [4:0] OP_CLR = 5'd4,  OP_EQ  = 5'd5,  OP_NE  = 5'd6,  OP_LT  = 5'd7;
  localparam logic [4:0] OP_GE  = 5'd8,  OP_LTU = 5'd9,  OP_GEU = 5'd10, OP_OPA = 5'd11;
  localparam logic [4:0] OP_OPB = 5'd12, OP_SLL = 5'd14, OP_SRL = 5'd15;
  localparam logic [4:0] OP_SRA = 5'd16, OP_MUL = 5'd17, OP_DIVU = 5'd18, OP_REMU = 5'd19;

  typedef enum logic [2:0] {ST_IDLE, ST_SHIFT, ST_MUL, ST_DIV, ST_DONE} state_t;

  state_t           state_r, state_n_s;
  logic [WIDTH-1:0] a_r, a_n_s, b_r, b_n_s, acc_r, acc_n_s, out_r, out_n_s;
  logic [4:0]       op_r, op_n_s;
  logic [CW-1:0]    cnt_r, cnt_n_s, step_s;
  logic [WIDTH-1:0] shifted_s, prod_s, rem_n_s, quo_n_s;
  logic [WIDTH:0]   div_tmp_s;
  logic             div_ge_s;

  // Ops that complete in one cycle; unlisted codes (13, 20..31) fall to XOR.
  function automatic logic [WIDTH-1:0] simple_result(input logic [4:0] opc,
                                                     input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = a ^ b;
    case (opc)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_CLR:  r = b & ~a;
      OP_EQ:   r = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_NE:   r = {{(WIDTH-1){1'b0}}, (a != b)};
      OP_LT:   r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_GE:   r = {{(WIDTH-1){1'b0}}, ($signed(a) >= $signed(b))};
      OP_LTU:  r = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_GEU:  r = {{(WIDTH-1){1'b0}}, (a >= b)};
      OP_OPA:  r = a;
      OP_OPB:  r = b;
      default: r = a ^ b;
    endcase
    return r;
  endfunction

  // Datapath step values plus FSM next-state; flush overrides everything.
  always_comb begin
    state_n_s = state_r;
    a_n_s     = a_r;
    b_n_s     = b_r;
    op_n_s    = op_r;
    cnt_n_s   = cnt_r;
    acc_n_s   = acc_r;
    out_n_s   = out_r;

    step_s = (cnt_r < STEP_C) ? cnt_r : STEP_C;
    case (op_r)
      OP_SLL:  shifted_s = acc_r << step_s;
      OP_SRA:  shifted_s = $signed(acc_r) >>> step_s;
      default: shifted_s = acc_r >> step_s;
    endcase

    prod_s    = acc_r + (b_r[0] ? a_r : {WIDTH{1'b0}});
    // Restoring division: remainder in acc_r, dividend shifts out of a_r as quotient shifts in.
    div_tmp_s = {acc_r, a_r[WIDTH-1]};
    div_ge_s  = (div_tmp_s >= {1'b0, b_r});
    rem_n_s   = div_ge_s ? WIDTH'(div_tmp_s - {1'b0, b_r}) : div_tmp_s[WIDTH-1:0];
    quo_n_s   = {a_r[WIDTH-2:0], div_ge_s};

    if (flush) begin
      state_n_s = ST_IDLE;
      cnt_n_s   = '0;
      acc_n_s   = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_n_s  = op_a;
            b_n_s  = op_b;
            op_n_s = op;
            case (op)
              OP_SLL, OP_SRL, OP_SRA: begin
                if (op_b[SW-1:0] == '0) begin
                  state_n_s = ST_DONE;
                  out_n_s   = op_a;
                end else begin
                  state_n_s = ST_SHIFT;
                  acc_n_s   = op_a;
                  cnt_n_s   = CW'(op_b[SW-1:0]);
                end
              end
              OP_MUL: begin
                state_n_s = ST_MUL;
                acc_n_s   = '0;
                cnt_n_s   = WIDTH_C;
              end
              OP_DIVU, OP_REMU: begin
                state_n_s = ST_DIV;
                acc_n_s   = '0;
                cnt_n_s   = WIDTH_C;
              end
              default: begin
                state_n_s = ST_DONE;
                out_n_s   = simple_result(op, op_a, op_b);
              end
            endcase
          end else begin
            state_n_s = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          acc_n_s = shifted_s;
          cnt_n_s = cnt_r - step_s;
          if (cnt_r == step_s) begin
            state_n_s = ST_DONE;
            out_n_s   = shifted_s;
          end else begin
            state_n_s = ST_SHIFT;
          end
        end
        ST_MUL: begin
          acc_n_s = prod_s;
          a_n_s   = a_r << 1;
          b_n_s   = b_r >> 1;
          cnt_n_s = cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_n_s = ST_DONE;
            out_n_s   = prod_s;
          end else begin
            state_n_s = ST_MUL;
          end
        end
        ST_DIV: begin
          acc_n_s = rem_n_s;
          a_n_s   = quo_n_s;
          cnt_n_s = cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_n_s = ST_DONE;
            out_n_s   = (op_r == OP_REMU) ? rem_n_s : quo_n_s;
          end else begin
            state_n_s = ST_DIV;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_n_s = ST_IDLE;
          end else begin
            state_n_s = ST_DONE;
          end
        end
        default: state_n_s = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      op_r    <= 5'd0;
      cnt_r   <= '0;
      acc_r   <= '0;
      out_r   <= '0;
    end else begin
      state_r <= state_n_s;
      a_r     <= a_n_s;
      b_r     <= b_n_s;
      op_r    <= op_n_s;
      cnt_r   <= cnt_n_s;
      acc_r   <= acc_n_s;
      out_r   <= out_n_s;
    end
  end

  assign in_ready  = reset && (state_r == ST_IDLE) && !flush;
  assign out_valid = (state_r == ST_DONE);
  assign busy      = (state_r != ST_IDLE);
  assign out       = out_r;

endmodule

// File: tb/tb_fwrisc_alu_seq.sv
// Directed self-checking bench for fwrisc_alu_seq at WIDTH=32, SHIFT_STEP=4.
module tb_fwrisc_alu_seq;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  op;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        busy;

  int errors = 0;
  int checks = 0;

  fwrisc_alu_seq #(.WIDTH(32), .SHIFT_STEP(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op(op), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // Present one op for one cycle, then scramble the operand inputs.
  task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; op_a = a; op_b = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0; op = 5'd13; op_a = 32'hDEADBEEF; op_b = 32'h0BADF00D;
  endtask

  // Cycles after accept until out_valid; 0 when it never arrives.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
    if (out_valid !== 1'b1) lat = 0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL reset_out: got %h want 0", out); end
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back;
    int lat;
    issue(5'd0, 32'hFFFFFFFF, 32'h1);
    wait_valid(lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_lat: got %0d want 1", lat); end
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL add_out: got %h want 00000000", out); end
    step();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: ready=%b valid=%b want 1/0", in_ready, out_valid); end
    issue(5'd1, 32'd3, 32'd5);
    wait_valid(lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL sub_lat: got %0d want 1", lat); end
    checks++; if (out !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_out: got %h want fffffffe", out); end
    step();
  endtask

  task automatic test_logic;
    logic [4:0]  ops [12] = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd10, 5'd11, 5'd12, 5'd13, 5'd7, 5'd9};
    logic [31:0] as  [12] = '{32'hF0F0, 32'hF0F0, 32'h0F, 32'd5, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'hAAAA5555, 32'h1, 32'hFF00, 32'd3, 32'd3};
    logic [31:0] bs  [12] = '{32'hFF00, 32'h0F00, 32'hFF, 32'd6, 32'd6, 32'd1, 32'd1,
                              32'h77, 32'h1234, 32'h0FF0, 32'd3, 32'd4};
    logic [31:0] ex  [12] = '{32'hF000, 32'hFFF0, 32'hF0, 32'd0, 32'd1, 32'd0, 32'd1,
                              32'hAAAA5555, 32'h1234, 32'hF0F0, 32'd0, 32'd1};
    int lat;
    for (int i = 0; i < 12; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_valid(lat);
      checks++; if (lat !== 1 || out !== ex[i]) begin errors++; $display("FAIL logic_op%0d: got %h lat %0d want %h lat 1", ops[i], out, lat, ex[i]); end
      step();
    end
  endtask

  task automatic test_shift;
    logic [4:0]  ops [4] = '{5'd16, 5'd14, 5'd15, 5'd14};
    logic [31:0] as  [4] = '{32'h80000000, 32'h12345678, 32'hF0000000, 32'h1};
    logic [31:0] bs  [4] = '{32'd31, 32'h20, 32'd5, 32'd4};
    logic [31:0] ex  [4] = '{32'hFFFFFFFF, 32'h12345678, 32'h07800000, 32'h10};
    int          el  [4] = '{9, 1, 3, 2};
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_valid(lat);
      checks++; if (lat !== el[i]) begin errors++; $display("FAIL shift%0d_lat: got %0d want %0d", i, lat, el[i]); end
      checks++; if (out !== ex[i]) begin errors++; $display("FAIL shift%0d_out: got %h want %h", i, out, ex[i]); end
      step();
    end
  endtask

  task automatic test_mul;
    int lat;
    issue(5'd17, 32'h10001, 32'h10001);
    wait_valid(lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mul_lat: got %0d want 33", lat); end
    checks++; if (out !== 32'h00020001) begin errors++; $display("FAIL mul_out: got %h want 00020001", out); end
    step();
    out_ready = 1'b0;
    issue(5'd17, 32'h10001, 32'h10001);
    wait_valid(lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mul_stall_lat: got %0d want 33", lat); end
    in_valid = 1'b1; op = 5'd0; op_a = 32'd1; op_b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out !== 32'h00020001) begin
        errors++; $display("FAIL mul_hold%0d: valid=%b ready=%b out=%h want 1/0/00020001", i, out_valid, in_ready, out);
      end
      step();
    end
    out_ready = 1'b1;
    checks++; if (out_valid !== 1'b1 || out !== 32'h00020001) begin errors++; $display("FAIL mul_consume: valid=%b out=%h want 1/00020001", out_valid, out); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mul_after: valid=%b ready=%b want 0/1", out_valid, in_ready); end
    step();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL busy_ignore: valid=%b busy=%b want 0/0", out_valid, busy); end
  endtask

  task automatic test_div;
    logic [4:0]  ops [4] = '{5'd18, 5'd19, 5'd18, 5'd19};
    logic [31:0] as  [4] = '{32'd100, 32'd100, 32'd12345, 32'd9};
    logic [31:0] bs  [4] = '{32'd7, 32'd7, 32'd0, 32'd0};
    logic [31:0] ex  [4] = '{32'd14, 32'd2, 32'hFFFFFFFF, 32'd9};
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_valid(lat);
      checks++; if (lat !== 33) begin errors++; $display("FAIL div%0d_lat: got %0d want 33", i, lat); end
      checks++; if (out !== ex[i]) begin errors++; $display("FAIL div%0d_out: got %h want %h", i, out, ex[i]); end
      step();
    end
  endtask

  task automatic test_flush;
    int lat;
    int seen;
    issue(5'd18, 32'd1000, 32'd3);
    repeat (9) step();
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    step();
    flush = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_idle: ready=%b busy=%b valid=%b want 1/0/0", in_ready, busy, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) seen++;
      step();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_result: got %0d valid cycles want 0", seen); end
    issue(5'd5, 32'd5, 32'd5);
    wait_valid(lat);
    checks++; if (lat !== 1 || out !== 32'd1) begin errors++; $display("FAIL flush_eq: got %h lat %0d want 1 lat 1", out, lat); end
    step();
  endtask

  task automatic test_reset_mid_op;
    int lat;
    issue(5'd17, 32'h1234, 32'h5678);
    repeat (5) step();
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out !== 32'h0) begin
      errors++; $display("FAIL async_reset: valid=%b busy=%b ready=%b out=%h want 0/0/0/0", out_valid, busy, in_ready, out);
    end
    step();
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_mid_release: ready=%b busy=%b want 1/0", in_ready, busy); end
    step();
    issue(5'd7, 32'hFFFFFFFF, 32'd1);
    wait_valid(lat);
    checks++; if (lat !== 1 || out !== 32'd1) begin errors++; $display("FAIL lt_signed: got %h lat %0d want 1", out, lat); end
    step();
    issue(5'd9, 32'hFFFFFFFF, 32'd1);
    wait_valid(lat);
    checks++; if (lat !== 1 || out !== 32'd0) begin errors++; $display("FAIL ltu: got %h lat %0d want 0", out, lat); end
    step();
    issue(5'd25, 32'hF0, 32'hFF);
    wait_valid(lat);
    checks++; if (lat !== 1 || out !== 32'h0F) begin errors++; $display("FAIL op25_xor: got %h lat %0d want 0000000f", out, lat); end
    step();
  endtask

  initial begin
    in_valid = 1'b0; op = 5'd0; op_a = 32'h0; op_b = 32'h0;
    flush = 1'b0; out_ready = 1'b1; reset = 1'b0;
    test_reset();
    step();
    test_back_to_back();
    test_logic();
    test_shift();
    test_mul();
    test_div();
    test_flush();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
